// File: rtl/cic_stream_controller_if.sv
// Stream bundle between upstream source, CIC decimator and downstream sink.
// The master modport is the controller's view; slave is the surrounding environment.
interface cic_stream_controller_if #(
    parameter int unsigned InputLengthBits  = 12,
    parameter int unsigned OutputLengthBits = 36
);
    logic                               enable;
    logic                               busy;
    logic signed [InputLengthBits-1:0]  in;
    logic                               in_valid;
    logic                               in_ready;
    logic                               cic_rst;
    logic signed [InputLengthBits-1:0]  cic_in;
    logic                               cic_in_valid;
    logic signed [OutputLengthBits-1:0] cic_out;
    logic                               cic_out_valid;
    logic                               cic_out_ready;
    logic signed [OutputLengthBits-1:0] out;
    logic                               out_valid;
    logic                               out_ready;

    modport master (
        input  enable,
        output busy,
        input  in,
        input  in_valid,
        output in_ready,
        output cic_rst,
        output cic_in,
        output cic_in_valid,
        input  cic_out,
        input  cic_out_valid,
        output cic_out_ready,
        output out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output enable,
        input  busy,
        output in,
        output in_valid,
        input  in_ready,
        input  cic_rst,
        input  cic_in,
        input  cic_in_valid,
        output cic_out,
        output cic_out_valid,
        input  cic_out_ready,
        input  out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/cic_stream_controller.sv
// Sequences a CIC decimator: clears it on start, discards settling outputs, then
// streams decimated samples downstream with at most one decimator output outstanding.
module cic_stream_controller #(
    parameter int unsigned InputLengthBits  = 12,
    parameter int unsigned OutputLengthBits = 36,
    parameter int unsigned DecimationFactor = 8,
    parameter int unsigned SettleOutputs    = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    cic_stream_controller_if.master bus
);
    localparam int unsigned PhaseW = $clog2(DecimationFactor);
    localparam int unsigned DiscW  = (SettleOutputs > 0) ? $clog2(SettleOutputs + 1) : 1;
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(DecimationFactor - 1);
    localparam logic [DiscW-1:0]  DiscLast  = DiscW'(SettleOutputs - 1);

    typedef enum logic [2:0] {StIdle, StClear, StSettle, StRun, StDrain} state_e;

    state_e                             state_q, state_d;
    logic                               clr_cnt_q, clr_cnt_d;
    logic [PhaseW-1:0]                  phase_q, phase_d;
    logic                               inflight_q, inflight_d;
    logic [DiscW-1:0]                   discard_q, discard_d;
    logic signed [OutputLengthBits-1:0] out_q, out_d;
    logic                               out_valid_q, out_valid_d;

    logic signed [InputLengthBits-1:0] sample;
    logic in_ready, cic_out_ready, accept, cic_hs, out_hs, load, at_last;

    always_comb begin
        sample        = bus.in;
        at_last       = (phase_q == PhaseLast);
        in_ready      = 1'b0;
        cic_out_ready = 1'b0;
        case (state_q)
            StIdle, StClear: cic_out_ready = 1'b1;
            StSettle: begin
                cic_out_ready = 1'b1;
                in_ready      = !(at_last && (inflight_q || out_valid_q));
            end
            StRun: begin
                cic_out_ready = !out_valid_q || bus.out_ready;
                in_ready      = !(at_last && (inflight_q || out_valid_q));
            end
            StDrain: cic_out_ready = !out_valid_q || bus.out_ready;
            default: ;
        endcase
        // Reset must drop the decimator handshake immediately, not at the next edge.
        cic_out_ready = cic_out_ready && rst_n;
        accept        = bus.in_valid && in_ready;
        cic_hs        = bus.cic_out_valid && cic_out_ready;
        out_hs        = out_valid_q && bus.out_ready;
        load          = cic_hs && ((state_q == StRun) || (state_q == StDrain));
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        phase_d     = phase_q;
        inflight_d  = inflight_q;
        discard_d   = discard_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            phase_d = at_last ? '0 : phase_q + PhaseW'(1);
        end
        if (accept && at_last) begin
            inflight_d = 1'b1;
        end else if (cic_hs) begin
            inflight_d = 1'b0;
        end
        if (load) begin
            out_d       = bus.cic_out;
            out_valid_d = 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                clr_cnt_d = 1'b0;
                if (bus.enable) state_d = StClear;
            end
            StClear: begin
                clr_cnt_d  = 1'b1;
                phase_d    = '0;
                inflight_d = 1'b0;
                discard_d  = '0;
                if (!bus.enable)    state_d = StIdle;
                else if (clr_cnt_q) state_d = StSettle;
            end
            StSettle: begin
                if (cic_hs) discard_d = discard_q + DiscW'(1);
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (SettleOutputs == 0 || (cic_hs && discard_q == DiscLast)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!bus.enable) state_d = StDrain;
            end
            StDrain: begin
                // enable is deliberately ignored here; a restart must go through IDLE/CLEAR.
                if (!inflight_q && !out_valid_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            clr_cnt_q   <= 1'b0;
            phase_q     <= '0;
            inflight_q  <= 1'b0;
            discard_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            phase_q     <= phase_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy          = (state_q != StIdle);
    assign bus.cic_rst       = (state_q == StIdle) || (state_q == StClear);
    assign bus.in_ready      = in_ready;
    assign bus.cic_in        = sample;
    assign bus.cic_in_valid  = accept;
    assign bus.cic_out_ready = cic_out_ready;
    assign bus.out           = out_q;
    assign bus.out_valid     = out_valid_q;
endmodule

// File: tb/tb_cic_stream_controller.sv
// Bench for cic_stream_controller: a stand-in decimator plus a frame-level reference model
// feeding a scoreboard, with directed reset/settle/stall/drain scenarios around random traffic.
module tb_cic_stream_controller;
    localparam int unsigned InW    = 12;
    localparam int unsigned OutW   = 36;
    localparam int unsigned Dec    = 8;
    localparam int unsigned Settle = 3;
    localparam int          Gain   = -512;  // held 987 over a frame of 8 gives -4042752

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cic_stream_controller_if #(.InputLengthBits(InW), .OutputLengthBits(OutW)) bus ();

    cic_stream_controller #(
        .InputLengthBits (InW),
        .OutputLengthBits(OutW),
        .DecimationFactor(Dec),
        .SettleOutputs   (Settle)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Stand-in decimator: one output per 8 samples, random latency, cleared by cic_rst.
    logic signed [OutW-1:0] stub_acc;
    logic signed [OutW-1:0] stub_q[$];
    int stub_cnt, stub_wait;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.cic_rst) begin
            stub_acc <= '0;
            stub_cnt <= 0;
            stub_wait <= 0;
            stub_q.delete();
            bus.cic_out_valid <= 1'b0;
            bus.cic_out <= '0;
        end else begin
            if (stub_wait > 0) stub_wait <= stub_wait - 1;
            if (bus.cic_in_valid) begin
                if (stub_cnt == Dec - 1) begin
                    stub_q.push_back(OutW'(Gain * (stub_acc + bus.cic_in)));
                    stub_acc <= '0;
                    stub_cnt <= 0;
                    stub_wait <= int'($urandom_range(4, 1));
                end else begin
                    stub_acc <= stub_acc + bus.cic_in;
                    stub_cnt <= stub_cnt + 1;
                end
            end
            if (bus.cic_out_valid && bus.cic_out_ready) bus.cic_out_valid <= 1'b0;
            if ((!bus.cic_out_valid || bus.cic_out_ready) && stub_wait == 0 &&
                stub_q.size() != 0) begin
                bus.cic_out <= stub_q.pop_front();
                bus.cic_out_valid <= 1'b1;
            end
        end
    end

    // Reference: group accepted samples into frames per session; the first Settle
    // frames of every session are discarded, every later frame must reach the output.
    logic signed [InW-1:0]  ref_samples[$];
    logic signed [63:0]     exp_q[$];
    int ref_frames;
    int total_frames = 0;

    function automatic logic signed [63:0] frame_value(input logic signed [InW-1:0] s[$]);
        longint sum = 0;
        foreach (s[i]) sum += longint'(s[i]);
        return Gain * sum;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            ref_samples.delete();
            ref_frames <= 0;
        end else if (bus.cic_rst) begin
            ref_samples.delete();
            ref_frames <= 0;
        end else if (bus.in_valid && bus.in_ready) begin
            ref_samples.push_back(bus.in);
            if (ref_samples.size() == Dec) begin
                if (ref_frames >= Settle) exp_q.push_back(frame_value(ref_samples));
                ref_samples.delete();
                ref_frames <= ref_frames + 1;
                total_frames <= total_frames + 1;
            end
        end
    end

    // Monitor: scoreboard pops on every downstream handshake.
    int  out_cnt = 0;
    int  pre_cnt;
    logic seen_out;
    always @(posedge clk) begin
        if (!rst_n || bus.cic_rst) begin
            pre_cnt <= 0;
            seen_out <= 1'b0;
        end else begin
            if (bus.out_valid && !seen_out) begin
                seen_out <= 1'b1;
                // Settle discards plus the handshake that loaded the first output.
                check("settle_discards", pre_cnt, Settle + 1);
            end
            if (bus.cic_out_valid && bus.cic_out_ready && !seen_out && !bus.out_valid)
                pre_cnt <= pre_cnt + 1;
            if (bus.out_valid && bus.out_ready) begin
                out_cnt <= out_cnt + 1;
                check("sb_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_out", bus.out, exp_q.pop_front());
            end
        end
    end

    task automatic wait_outs(input int n, input int bound, input string name);
        int target;
        int k;
        target = out_cnt + n;
        k = 0;
        while (out_cnt < target && k < bound) begin @(negedge clk); k++; end
        check(name, out_cnt >= target, 1);
    endtask

    task automatic wait_busy(input logic val, input int bound, input string name);
        int k;
        k = 0;
        while (bus.busy !== val && k < bound) begin @(negedge clk); k++; end
        check(name, bus.busy, val);
    endtask

    task automatic wait_out_valid(input int bound, input string name);
        int k;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < bound) begin @(negedge clk); k++; end
        check(name, bus.out_valid, 1);
    endtask

    task automatic run_random(input int cycles, input int ready_pct);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.in       = InW'($urandom);
            bus.in_valid = ($urandom_range(3, 0) != 0);
            bus.out_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end
    endtask

    task automatic check_clear_then_settle(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, bus.busy, 1);
        check({tag, "_clear1"}, bus.cic_rst, 1);
        @(negedge clk);
        check({tag, "_clear2"}, bus.cic_rst, 1);
        @(negedge clk);
        check({tag, "_settle"}, bus.cic_rst, 0);
    endtask

    initial begin
        int f0;
        int k;
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.in_valid = 1'b1;
        bus.in = '0;
        bus.out_ready = 1'b1;

        repeat (100) begin
            @(negedge clk);
            bus.in = InW'($urandom);
            check("rst_cic_rst", bus.cic_rst, 1);
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_cic_out_ready", bus.cic_out_ready, 0);
            check("rst_out", bus.out, 0);
        end

        bus.enable = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_cic_rst", bus.cic_rst, 1);
            check("idle_cic_out_ready", bus.cic_out_ready, 1);
            check("idle_in_ready", bus.in_ready, 0);
        end

        // Held 987: three outputs discarded, then a constant stream.
        bus.in = 987;
        bus.enable = 1'b1;
        check_clear_then_settle("start");
        wait_out_valid(200, "first_out_timeout");
        check("out_987_first", bus.out, -4042752);
        wait_outs(5, 200, "out_987_timeout");
        check("out_987_last", bus.out, -4042752);

        // Downstream stall: output held, input stops one short of completing a frame.
        bus.out_ready = 1'b0;
        repeat (60) begin @(negedge clk); bus.in = InW'($urandom); end
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_phase", ref_samples.size(), Dec - 1);
            check("stall_out_hold", bus.out, (exp_q.size() != 0) ? exp_q[0] : 'x);
        end
        bus.out_ready = 1'b1;
        wait_outs(2, 100, "stall_release_timeout");
        run_random(300, 70);

        // Drain with a decimator output in flight; enable re-asserted must be ignored.
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        f0 = total_frames;
        k = 0;
        while (total_frames == f0 && k < 40) begin @(negedge clk); k++; end
        check("drain_frame_timeout", total_frames != f0, 1);
        bus.enable = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("drain_in_ready", bus.in_ready, 0);
        check("drain_busy", bus.busy, 1);
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("drain_busy_hold", bus.busy, 1);
        end
        check("drain_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        wait_busy(1'b0, 20, "drain_exit");
        check("drain_sb_empty", exp_q.size(), 0);
        check_clear_then_settle("restart");

        // Abort during settling.
        repeat (10) begin
            @(negedge clk);
            bus.in = InW'($urandom);
            check("abort_no_out", bus.out_valid, 0);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_cic_rst", bus.cic_rst, 1);
        bus.enable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("abort_restart_no_out", bus.out_valid, 0);
        end
        run_random(300, 80);

        // Reset while an output is held.
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        wait_out_valid(60, "pre_reset_out_timeout");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out", bus.out, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cic_rst", bus.cic_rst, 1);
        check("mid_rst_cic_out_ready", bus.cic_out_ready, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.in = 987;
        bus.out_ready = 1'b1;
        check_clear_then_settle("post_rst");
        wait_outs(4, 300, "post_rst_out_timeout");
        check("post_rst_out", bus.out, -4042752);

        bus.enable = 1'b0;
        wait_busy(1'b0, 50, "final_idle");
        check("final_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
